// File: rtl/gaussian_pkg.sv
// Shared constants for the Gaussian window stage.
//   BITS     pixel width
//   WIDTH    window side (7x7 window, WIDTH-1 line buffers)
//   MASKLEN  flattened window bus width
//   ROW/COL  default frame geometry
//   ADDRLEN  output write address width
//   tap_idx  flat tap index of window row r, column c
package gaussian_pkg;
  localparam int BITS    = 8;
  localparam int WIDTH   = 7;
  localparam int MASKLEN = WIDTH * WIDTH * BITS;
  localparam int ROW     = 720;
  localparam int COL     = 1280;
  localparam int ADDRLEN = 21;
  localparam int NLINES  = WIDTH - 1;

  function automatic int tap_idx(input int r, input int c);
    return r * WIDTH + c;
  endfunction
endpackage

// File: rtl/gaussian_line_ram.sv
// One line buffer: DEPTH x DW synchronous single-port RAM.
// A write returns the previous contents of the addressed word on rdata.
//   clk    clock
//   en     port enable; rdata only changes when en is high
//   we     write enable (qualified by en)
//   addr   word address
//   wdata  write data
//   rdata  registered read data (old data on read-during-write)
module gaussian_line_ram
  import gaussian_pkg::*;
#(
  parameter int DEPTH = COL,
  parameter int DW    = BITS,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      if (we) mem[addr] <= wdata;
    end
  end
endmodule

// File: rtl/gaussian_window_buf.sv
// Raster-to-window stage feeding the Gaussian filter. Takes one pixel per
// handshake in row-major order, keeps WIDTH-1 line buffers plus a WIDTHxWIDTH
// register window, and emits one window per valid centre with its address.
//   clk, rst_n   clock, asynchronous active-low reset
//   pix_valid    input pixel valid
//   pix_sof      pixel is (0,0) of a new frame (qualified by pix_valid)
//   pix_in       input pixel
//   pix_ready    pixel accepted when pix_valid && pix_ready
//   win_valid    window valid
//   win_data     window, tap (r,c) at [(r*WIDTH+c)*BITS +: BITS], r=0 oldest row
//   win_addr     write address of the window centre
//   win_ready    downstream accepts window
//   frame_done   one-cycle pulse after the last window of a frame is accepted
module gaussian_window_buf
  import gaussian_pkg::*;
#(
  parameter int ROW = gaussian_pkg::ROW,
  parameter int COL = gaussian_pkg::COL
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid,
  input  logic               pix_sof,
  input  logic [BITS-1:0]    pix_in,
  output logic               pix_ready,
  output logic               win_valid,
  output logic [MASKLEN-1:0] win_data,
  output logic [ADDRLEN-1:0] win_addr,
  input  logic               win_ready,
  output logic               frame_done
);
  localparam int XW   = $clog2(COL);
  localparam int YW   = $clog2(ROW);
  localparam int PW   = $clog2(NLINES);
  localparam int HALF = WIDTH / 2;
  localparam logic [XW-1:0] X_LAST = XW'(COL - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROW - 1);
  localparam logic [XW-1:0] X_MIN  = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_MIN  = YW'(WIDTH - 1);
  localparam logic [PW-1:0] P_LAST = PW'(NLINES - 1);

  logic          pipe_en, acc, abort;
  logic [XW-1:0] x, cur_x;
  logic [YW-1:0] y, cur_y;
  logic [PW-1:0] ptr, cur_ptr;

  assign pipe_en   = !(win_valid && !win_ready);
  assign pix_ready = pipe_en;
  assign acc       = pix_valid && pipe_en;
  // A start-of-frame on a non-zero position abandons the partial frame.
  assign abort     = acc && pix_sof && (x != '0 || y != '0);

  // ptr names the line buffer holding the oldest row (y-6). Rotating which
  // buffer receives the new row is equivalent to shifting every buffer up one
  // row, and keeps each buffer a plain single-port RAM.
  always_comb begin
    cur_x   = pix_sof ? '0 : x;
    cur_y   = pix_sof ? '0 : y;
    cur_ptr = pix_sof ? '0 : ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x   <= '0;
      y   <= '0;
      ptr <= '0;
    end else if (acc) begin
      if (cur_x == X_LAST) begin
        x   <= '0;
        y   <= (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
        ptr <= (cur_ptr == P_LAST) ? '0 : cur_ptr + 1'b1;
      end else begin
        x   <= cur_x + 1'b1;
        y   <= cur_y;
        ptr <= cur_ptr;
      end
    end
  end

  // ---- S1: pixel/coordinate register and line-buffer read ----
  logic [BITS-1:0] lb_rd [NLINES];

  for (genvar i = 0; i < NLINES; i++) begin : g_lb
    gaussian_line_ram #(.DEPTH(COL), .DW(BITS)) u_lb (
      .clk   (clk),
      .en    (acc),
      .we    (cur_ptr == PW'(i)),
      .addr  (cur_x),
      .wdata (pix_in),
      .rdata (lb_rd[i])
    );
  end

  logic            vld_p1;
  logic [BITS-1:0] pix_p1;
  logic [XW-1:0]   x_p1;
  logic [YW-1:0]   y_p1;
  logic [PW-1:0]   ptr_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       vld_p1 <= 1'b0;
    else if (pipe_en) vld_p1 <= acc;
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      pix_p1 <= pix_in;
      x_p1   <= cur_x;
      y_p1   <= cur_y;
      ptr_p1 <= cur_ptr;
    end
  end

  // ---- S2: shift window left, load new right column ----
  logic [BITS-1:0] col_new [WIDTH];
  logic [PW:0]     sel;

  always_comb begin
    sel = '0;
    for (int r = 0; r < NLINES; r++) begin
      sel = {1'b0, ptr_p1} + (PW+1)'(r);
      if (sel >= (PW+1)'(NLINES)) sel = sel - (PW+1)'(NLINES);
      col_new[r] = lb_rd[sel[PW-1:0]];
    end
    col_new[WIDTH-1] = pix_p1;
  end

  logic            vld_p2;
  logic [XW-1:0]   x_p2;
  logic [YW-1:0]   y_p2;
  logic [BITS-1:0] win_p2 [WIDTH][WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       vld_p2 <= 1'b0;
    else if (pipe_en) vld_p2 <= vld_p1 && !abort;
  end

  always_ff @(posedge clk) begin
    if (pipe_en && vld_p1) begin
      x_p2 <= x_p1;
      y_p2 <= y_p1;
      for (int r = 0; r < WIDTH; r++) begin
        for (int c = 0; c < WIDTH - 1; c++) win_p2[r][c] <= win_p2[r][c+1];
        win_p2[r][WIDTH-1] <= col_new[r];
      end
    end
  end

  // ---- Output register ----
  logic               hit, win_last;
  logic [MASKLEN-1:0] win_flat;
  logic [ADDRLEN-1:0] addr_p2;

  assign hit = vld_p2 && !abort && (x_p2 >= X_MIN) && (y_p2 >= Y_MIN);

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < WIDTH; r++)
      for (int c = 0; c < WIDTH; c++)
        win_flat[tap_idx(r, c)*BITS +: BITS] = win_p2[r][c];
    addr_p2 = ADDRLEN'(COL * (int'(y_p2) - HALF) + int'(x_p2) - HALF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid  <= 1'b0;
      win_last   <= 1'b0;
      win_data   <= '0;
      win_addr   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= win_valid && win_ready && win_last;
      if (pipe_en) begin
        win_valid <= hit;
        win_last  <= hit && (x_p2 == X_LAST) && (y_p2 == Y_LAST);
        if (hit) begin
          win_data <= win_flat;
          win_addr <= addr_p2;
        end
      end
    end
  end
endmodule

// File: tb/tb_gaussian_window_buf.sv
// Bench for gaussian_window_buf on a 10x12 frame; pixel value (y*12+x) mod 256.
// A frame-image model produces each expected window from the pixels accepted.
module tb_gaussian_window_buf;
  import gaussian_pkg::*;

  localparam int TR = 10;
  localparam int TC = 12;

  typedef logic [MASKLEN-1:0] vec_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               pix_valid, pix_sof, pix_ready;
  logic [BITS-1:0]    pix_in;
  logic               win_valid, win_ready, frame_done;
  logic [MASKLEN-1:0] win_data;
  logic [ADDRLEN-1:0] win_addr;

  always #5 clk = ~clk;

  gaussian_window_buf #(.ROW(TR), .COL(TC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_in     (pix_in),
    .pix_ready  (pix_ready),
    .win_valid  (win_valid),
    .win_data   (win_data),
    .win_addr   (win_addr),
    .win_ready  (win_ready),
    .frame_done (frame_done)
  );

  typedef struct {
    vec_t               data;
    logic [ADDRLEN-1:0] addr;
    bit                 last;
    int                 y;
    int                 x;
    int                 acc_cyc;
  } win_t;

  int   total = 0;
  int   bad   = 0;
  win_t expq[$];
  int   img[TR][TC];
  int   my = 0, mx = 0;
  int   nwin = 0, nfd = 0, cyc = 0;
  bit   fd_exp = 1'b0, no_stall = 1'b0, held = 1'b0;
  vec_t               held_data;
  logic [ADDRLEN-1:0] held_addr;

  task automatic chk(input string tag, input vec_t obs, input vec_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t exp_win(input int y, input int x);
    vec_t w = '0;
    for (int r = 0; r < WIDTH; r++)
      for (int c = 0; c < WIDTH; c++)
        w[(r*WIDTH+c)*BITS +: BITS] = BITS'(img[y-6+r][x-6+c]);
    return w;
  endfunction

  // One clock: check outputs, drive inputs, update the model on accept.
  task automatic step(input bit v, input bit sof, input bit rdy, output bit acc);
    int   ey, ex;
    bit   hs;
    win_t e;
    win_t ne;
    @(negedge clk);
    if (frame_done) nfd++;
    chk("frame_done", vec_t'(frame_done), vec_t'(fd_exp));
    if (held) begin
      chk("stall_data", win_data, held_data);
      chk("stall_addr", vec_t'(win_addr), vec_t'(held_addr));
    end
    ey = sof ? 0 : my;
    ex = sof ? 0 : mx;
    pix_valid = v;
    pix_sof   = sof;
    pix_in    = BITS'((ey * TC + ex) % 256);
    win_ready = rdy;
    #1;
    chk("pix_ready", vec_t'(pix_ready), vec_t'(!(win_valid && !rdy)));
    hs        = win_valid && rdy;
    held      = win_valid && !rdy;
    held_data = win_data;
    held_addr = win_addr;
    fd_exp    = 1'b0;
    if (win_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_window", vec_t'(win_valid), vec_t'(1'b0));
      end else begin
        e = expq[0];
        chk("win_data", win_data, e.data);
        chk("win_addr", vec_t'(win_addr), vec_t'(e.addr));
        // the accept edge comes after the step that drove the pixel
        if (no_stall) chk("latency", vec_t'(cyc - e.acc_cyc - 1), vec_t'(2));
        if (e.y == 6 && e.x == 6) begin
          chk("first_tap0", vec_t'(win_data[7:0]), vec_t'(0));
          chk("first_tap48", vec_t'(win_data[48*BITS +: BITS]), vec_t'(78));
          chk("first_addr", vec_t'(win_addr), vec_t'(39));
        end
        if (e.y == 9 && e.x == 11) begin
          chk("last_tap0", vec_t'(win_data[7:0]), vec_t'(41));
          chk("last_tap48", vec_t'(win_data[48*BITS +: BITS]), vec_t'(119));
          chk("last_addr", vec_t'(win_addr), vec_t'(80));
        end
        if (hs) begin
          void'(expq.pop_front());
          nwin++;
          fd_exp = e.last;
        end
      end
    end
    acc = v && pix_ready;
    if (acc) begin
      if (sof) begin my = 0; mx = 0; end
      img[my][mx] = (my * TC + mx) % 256;
      if (my >= 6 && mx >= 6) begin
        ne.data    = exp_win(my, mx);
        ne.addr    = ADDRLEN'(TC * (my - 3) + mx - 3);
        ne.last    = (my == TR - 1) && (mx == TC - 1);
        ne.y       = my;
        ne.x       = mx;
        ne.acc_cyc = cyc;
        expq.push_back(ne);
      end
      mx++;
      if (mx == TC) begin
        mx = 0;
        my++;
        if (my == TR) my = 0;
      end
    end
    cyc++;
  endtask

  task automatic feed(input int n, input bit sof_first, input bit rnd);
    int sent = 0;
    int guard = 0;
    bit a;
    while (sent < n && guard < 20 * n + 100) begin
      step(rnd ? ($urandom_range(0, 3) != 0) : 1'b1, sof_first && sent == 0,
           rnd ? 1'($urandom_range(0, 1)) : 1'b1, a);
      if (a) sent++;
      guard++;
    end
    chk("feed_progress", vec_t'(sent), vec_t'(n));
  endtask

  task automatic drain(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, a);
  endtask

  task automatic begin_scn(input bit ns);
    no_stall = ns;
    nwin = 0;
    nfd  = 0;
  endtask

  task automatic end_scn(input string tag, input int w, input int f);
    chk({tag, "_windows"}, vec_t'(nwin), vec_t'(w));
    chk({tag, "_frame_done"}, vec_t'(nfd), vec_t'(f));
    chk({tag, "_leftover"}, vec_t'(expq.size()), vec_t'(0));
  endtask

  initial begin
    rst_n = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; pix_in = '0; win_ready = 1'b0;
    #12;
    chk("rst_win_valid", vec_t'(win_valid), vec_t'(0));
    chk("rst_win_data", win_data, vec_t'(0));
    chk("rst_win_addr", vec_t'(win_addr), vec_t'(0));
    chk("rst_frame_done", vec_t'(frame_done), vec_t'(0));
    @(negedge clk);
    rst_n = 1'b1;

    begin_scn(1'b1); feed(120, 1'b1, 1'b0); drain(8);  end_scn("nostall", 24, 1);
    begin_scn(1'b0); feed(120, 1'b1, 1'b1); drain(20); end_scn("stall", 24, 1);

    // sof lands on the pixel that would have been (4,7)
    begin_scn(1'b1); feed(55, 1'b1, 1'b0); feed(120, 1'b1, 1'b0); drain(8);
    end_scn("abort", 24, 1);

    // reset right after pixel (7,3) is accepted
    begin_scn(1'b1); feed(88, 1'b1, 1'b0);
    @(negedge clk);
    pix_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_win_valid", vec_t'(win_valid), vec_t'(0));
    chk("midrst_win_data", win_data, vec_t'(0));
    chk("midrst_win_addr", vec_t'(win_addr), vec_t'(0));
    chk("midrst_frame_done", vec_t'(frame_done), vec_t'(0));
    expq.delete();
    my = 0; mx = 0; fd_exp = 1'b0; held = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    begin_scn(1'b1); feed(120, 1'b0, 1'b0); drain(8); end_scn("reset", 24, 1);

    begin_scn(1'b1); feed(120, 1'b1, 1'b0); feed(120, 1'b1, 1'b0); drain(8);
    end_scn("b2b", 48, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
